// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon seed, GF(2^8) doubling and the
// key-schedule FSM state type.
package aes_pkg;

  localparam int         AES_NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT      = 8'h01;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_EMIT = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. Byte 0x00 of the table sits in the
// MSBs, so the entry for byte a starts at bit 8*(255-a) = {~a, 3'b000}.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// On-the-fly AES-128 key expansion: holds only the current round key and
// derives the next one on each consumer handshake.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t    state_q, state_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         rk_last_q, rk_last_d;

  logic [31:0]  w3_rot;
  logic [31:0]  w3_sub;
  logic [31:0]  t_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;

  assign w3_rot = {rk_data_q[23:0], rk_data_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (w3_rot[8*i +: 8]),
      .out_o (w3_sub[8*i +: 8])
    );
  end

  assign t_word   = w3_sub ^ {rcon_q, 24'h000000};
  assign nw0      = rk_data_q[127:96] ^ t_word;
  assign nw1      = rk_data_q[95:64]  ^ nw0;
  assign nw2      = rk_data_q[63:32]  ^ nw1;
  assign nw3      = rk_data_q[31:0]   ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= KS_IDLE;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rcon_q     <= RCON_INIT;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rcon_q     <= rcon_d;
      rk_last_q  <= rk_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rcon_d     = rcon_q;
    rk_last_d  = rk_last_q;
    unique case (state_q)
      KS_IDLE: begin
        if (key_valid) begin
          state_d    = KS_EMIT;
          rk_data_d  = key_in;
          rk_round_d = 4'd0;
          rcon_d     = RCON_INIT;
          rk_last_d  = 1'b0;
        end
      end
      KS_EMIT: begin
        if (rk_ready) begin
          // The last key stays on rk_data after the final handshake; only valid drops.
          if (rk_round_q == LAST_ROUND) begin
            state_d = KS_IDLE;
          end else begin
            rk_data_d  = next_key;
            rk_round_d = rk_round_q + 4'd1;
            rcon_d     = xtime(rcon_q);
            rk_last_d  = (rk_round_q == (LAST_ROUND - 4'd1));
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  assign key_ready = (state_q == KS_IDLE);
  assign rk_valid  = (state_q == KS_EMIT);
  assign busy      = (state_q == KS_EMIT);
  assign rk_data   = rk_data_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: expected round keys come from an algebraic
// S-box model and are queued per schedule, then popped on each handshake.
module tb_aes_key_schedule_seq;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] data;
  } exp_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] OTHER_KEY = 128'hdeadbeef0123456789abcdeffeedface;
  localparam logic [7:0]   RCON_TAB [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  aes_key_schedule_seq #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_model(input logic [127:0] k, input int rnd);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox_model(rot[31:24]), sbox_model(rot[23:16]), sbox_model(rot[15:8]),
         sbox_model(rot[7:0])} ^ {RCON_TAB[rnd-1], 24'h000000};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic push_schedule(input logic [127:0] key);
    exp_t e;
    logic [127:0] k;
    k = key;
    for (int r = 0; r <= 10; r++) begin
      e.rnd = 4'(r);
      e.data = k;
      exp_q.push_back(e);
      if (r < 10) k = next_model(k, r + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
    checks++; if (rk_data !== 128'h0) begin errors++; $display("FAIL reset_rk_data: got %h want 0", rk_data); end
    checks++; if (rk_round !== 4'd0 || rk_last !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_round_last_busy: got %0d/%b/%b want 0/0/0", rk_round, rk_last, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: key_ready %b rk_valid %b want 1/0", key_ready, rk_valid);
    end
  endtask

  task automatic test_known_key(input string name, input logic [127:0] key,
                                input logic [127:0] r1, input logic [127:0] r10);
    push_schedule(key);
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, key_ready); end
    key_in = key; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL %s_valid cycle %0d: valid %b busy %b want 1/1", name, c, rk_valid, busy);
      end else begin
        checks++; if (rk_round !== exp_q[0].rnd || rk_data !== exp_q[0].data) begin
          errors++; $display("FAIL %s_key: round %0d %h want round %0d %h", name, rk_round, rk_data, exp_q[0].rnd, exp_q[0].data);
        end
        checks++; if (rk_last !== (exp_q[0].rnd == 4'd10)) begin
          errors++; $display("FAIL %s_last: round %0d rk_last %b", name, rk_round, rk_last);
        end
        if (c == 1) begin
          checks++; if (rk_data !== r1) begin errors++; $display("FAIL %s_round1: got %h want %h", name, rk_data, r1); end
        end
        if (c == 10) begin
          checks++; if (rk_data !== r10) begin errors++; $display("FAIL %s_round10: got %h want %h", name, rk_data, r10); end
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_end: valid %b ready %b busy %b want 0/1/0", name, rk_valid, key_ready, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [127:0] held_data;
    logic [3:0]   held_round;
    bit           stalled, rdy;
    int           c;
    push_schedule(FIPS_KEY);
    key_in = FIPS_KEY; key_valid = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0; stalled = 1'b0; held_data = '0; held_round = '0;
    for (c = 0; c < 300 && exp_q.size() > 0; c++) begin
      checks++;
      if (rk_valid !== 1'b1) begin
        errors++; $display("FAIL bp_valid cycle %0d: got %b want 1", c, rk_valid);
        break;
      end
      checks++; if (rk_round !== exp_q[0].rnd || rk_data !== exp_q[0].data || rk_last !== (exp_q[0].rnd == 4'd10)) begin
        errors++; $display("FAIL bp_key: round %0d %h last %b want round %0d %h", rk_round, rk_data, rk_last, exp_q[0].rnd, exp_q[0].data);
      end
      if (stalled) begin
        checks++; if (rk_data !== held_data || rk_round !== held_round) begin
          errors++; $display("FAIL bp_stable: round %0d %h want round %0d %h", rk_round, rk_data, held_round, held_data);
        end
      end
      rdy = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rk_ready = rdy;
      stalled = !rdy;
      held_data = rk_data; held_round = rk_round;
      if (rdy) void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d keys left want 0", exp_q.size()); end
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL bp_end: valid %b ready %b want 0/1", rk_valid, key_ready);
    end
    rk_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_key_ignored();
    push_schedule(FIPS_KEY);
    key_in = FIPS_KEY; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_in = OTHER_KEY;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      checks++; if (rk_valid !== 1'b1 || key_ready !== 1'b0) begin
        errors++; $display("FAIL ign_hs cycle %0d: valid %b ready %b want 1/0", c, rk_valid, key_ready);
      end
      checks++; if (rk_round !== exp_q[0].rnd || rk_data !== exp_q[0].data) begin
        errors++; $display("FAIL ign_key: round %0d %h want round %0d %h", rk_round, rk_data, exp_q[0].rnd, exp_q[0].data);
      end
      rk_ready = ((c % 3) != 1);
      if (rk_ready) begin
        if (exp_q[0].rnd == 4'd10) key_valid = 1'b0;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ign_timeout: %0d keys left want 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL ign_end: valid %b ready %b want 0/1", rk_valid, key_ready);
    end
    rk_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    logic [127:0] k;
    int c;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_schedule(k);
    key_in = k; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (c = 0; c < 20 && rk_round != 4'd5; c++) begin
      checks++; if (rk_valid !== 1'b1 || rk_data !== exp_q[0].data) begin
        errors++; $display("FAIL abort_pre: round %0d %h want %h", rk_round, rk_data, exp_q[0].data);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (rk_round !== 4'd5 || rk_valid !== 1'b1) begin
      errors++; $display("FAIL abort_reach5: round %0d valid %b want 5/1", rk_round, rk_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_hs: valid %b ready %b busy %b want 0/1/0", rk_valid, key_ready, busy);
    end
    checks++; if (rk_data !== 128'h0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
      errors++; $display("FAIL abort_data: %h round %0d last %b want 0/0/0", rk_data, rk_round, rk_last);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_schedule(k);
    key_in = k; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    for (c = 0; c < 11; c++) begin
      checks++; if (rk_valid !== 1'b1 || rk_round !== exp_q[0].rnd || rk_data !== exp_q[0].data
                    || rk_last !== (exp_q[0].rnd == 4'd10)) begin
        errors++; $display("FAIL abort_after: valid %b round %0d %h want round %0d %h", rk_valid, rk_round, rk_data, exp_q[0].rnd, exp_q[0].data);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL abort_end: valid %b want 0", rk_valid); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    int bubbles, c;
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_schedule(ka);
    push_schedule(kb);
    key_in = ka; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key_in = kb;
    bubbles = 0;
    for (c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rk_valid === 1'b1) begin
        checks++; if (rk_round !== exp_q[0].rnd || rk_data !== exp_q[0].data || rk_last !== (exp_q[0].rnd == 4'd10)) begin
          errors++; $display("FAIL b2b_key: round %0d %h want round %0d %h", rk_round, rk_data, exp_q[0].rnd, exp_q[0].data);
        end
        if (exp_q.size() == 11) key_valid = 1'b0;
        void'(exp_q.pop_front());
      end else begin
        bubbles++;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL b2b_bubble_ready: got %b want 1", key_ready); end
      end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: %0d keys left want 0", exp_q.size()); end
    checks++; if (bubbles != 1) begin errors++; $display("FAIL b2b_bubbles: got %0d want 1", bubbles); end
    key_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_known_key("fips", FIPS_KEY, FIPS_R1, FIPS_R10);
    test_known_key("zero", 128'h0, ZERO_R1, ZERO_R10);
    test_backpressure();
    test_key_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
